// File: rtl/vram_dma.sv
// CPU-side VRAM block copier: clears the vblank IRQ, waits for blanking, then
// streams bytes from a source port into VRAM, aborting if blanking ends early.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 10
`endif

module vram_dma #(
  parameter int unsigned ADDR_W = `VRAM_ADDR_WIDTH,
  parameter int unsigned SRC_W  = 16,
  parameter int unsigned LEN_W  = 12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_auto_en,
  input  logic [SRC_W-1:0]  i_src_base,
  input  logic [ADDR_W-1:0] i_dst_base,
  input  logic [LEN_W-1:0]  i_length,
  output logic [SRC_W-1:0]  o_src_addr,
  output logic              o_src_req,
  input  logic              i_src_ack,
  input  logic [7:0]        i_src_data,
  output logic [ADDR_W-1:0] o_address,
  output logic [7:0]        o_data_out,
  output logic              o_data_oe,
  input  logic [7:0]        i_data_in,
  output logic              o_write_enable,
  output logic              o_select_in_vblank,
  output logic              o_select_clr_vblank_irq,
  input  logic              i_vblank_irq,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overrun
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_FETCH = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;
  localparam logic [2:0] S_ABORT = 3'd6;

  logic [2:0]        r_state;
  logic [2:0]        w_state_d;
  logic [SRC_W-1:0]  r_src_base;
  logic [ADDR_W-1:0] r_dst_base;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic [LEN_W-1:0]  w_idx_inc;
  logic [7:0]        r_byte;
  logic              r_overrun;
  logic              r_irq_q;
  logic              w_launch;
  logic              w_abort;
  logic              w_unused;

  assign w_unused  = ^i_data_in[7:1];
  assign w_idx_inc = r_idx + LEN_W'(1);
  assign w_launch  = (r_state == S_IDLE) &&
                     (i_start || (i_auto_en && i_vblank_irq && !r_irq_q));
  // Blanking ended after the transfer had already started writing
  assign w_abort   = (r_state == S_CHECK) && !i_data_in[0] && (r_idx != '0);

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_state_d = (i_length == '0) ? S_FIN : S_CLR;
      S_CLR:   w_state_d = S_CHECK;
      S_CHECK: begin
        if (i_data_in[0]) w_state_d = S_FETCH;
        else if (w_abort) w_state_d = S_ABORT;
      end
      S_FETCH: if (i_src_ack) w_state_d = S_WRITE;
      S_WRITE: w_state_d = (w_idx_inc == r_len) ? S_FIN : S_CHECK;
      S_FIN:   w_state_d = S_IDLE;
      S_ABORT: w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_src_base <= '0;
      r_dst_base <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_byte     <= '0;
      r_overrun  <= 1'b0;
      r_irq_q    <= 1'b0;
    end else begin
      r_irq_q <= i_vblank_irq;
      r_state <= w_state_d;
      if (w_launch) begin
        r_src_base <= i_src_base;
        r_dst_base <= i_dst_base;
        r_len      <= i_length;
        r_idx      <= '0;
        r_overrun  <= 1'b0;
      end
      if ((r_state == S_FETCH) && i_src_ack) r_byte <= i_src_data;
      if (r_state == S_WRITE) r_idx <= w_idx_inc;
      if (w_abort) r_overrun <= 1'b1;
    end
  end

  always_comb begin
    o_src_addr              = '0;
    o_src_req               = 1'b0;
    o_address               = '0;
    o_data_out              = '0;
    o_data_oe               = 1'b0;
    o_write_enable          = 1'b0;
    o_select_in_vblank      = 1'b0;
    o_select_clr_vblank_irq = 1'b0;
    o_done                  = 1'b0;
    case (r_state)
      S_CLR: begin
        o_write_enable          = 1'b1;
        o_select_clr_vblank_irq = 1'b1;
        o_data_oe               = 1'b1;
      end
      S_CHECK: o_select_in_vblank = 1'b1;
      S_FETCH: begin
        o_src_req  = 1'b1;
        o_src_addr = r_src_base + SRC_W'(r_idx);
      end
      S_WRITE: begin
        o_address      = r_dst_base + ADDR_W'(r_idx);
        o_data_out     = r_byte;
        o_data_oe      = 1'b1;
        o_write_enable = 1'b1;
      end
      S_FIN:   o_done = 1'b1;
      S_ABORT: o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_busy    = (r_state != S_IDLE);
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_vram_dma.sv
// Scoreboard bench for vram_dma: a transfer-level model queues expected VRAM
// writes and completions; a negedge monitor pops and compares them.
module tb_vram_dma;
  localparam int AW = 10;
  localparam int SW = 16;
  localparam int LW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_auto_en = 1'b0;
  logic [SW-1:0] i_src_base = '0;
  logic [AW-1:0] i_dst_base = '0;
  logic [LW-1:0] i_length = '0;
  logic [SW-1:0] o_src_addr;
  logic          o_src_req;
  logic          i_src_ack = 1'b0;
  logic [7:0]    i_src_data = '0;
  logic [AW-1:0] o_address;
  logic [7:0]    o_data_out;
  logic          o_data_oe;
  logic [7:0]    i_data_in = '0;
  logic          o_write_enable;
  logic          o_sel_in;
  logic          o_sel_clr;
  logic          i_vblank_irq = 1'b0;
  logic          o_busy;
  logic          o_done;
  logic          o_overrun;

  vram_dma #(.ADDR_W(AW), .SRC_W(SW), .LEN_W(LW)) dut (
    .i_clk                   (clk),
    .i_rst_n                 (rst_n),
    .i_start                 (i_start),
    .i_auto_en               (i_auto_en),
    .i_src_base              (i_src_base),
    .i_dst_base              (i_dst_base),
    .i_length                (i_length),
    .o_src_addr              (o_src_addr),
    .o_src_req               (o_src_req),
    .i_src_ack               (i_src_ack),
    .i_src_data              (i_src_data),
    .o_address               (o_address),
    .o_data_out              (o_data_out),
    .o_data_oe               (o_data_oe),
    .i_data_in               (i_data_in),
    .o_write_enable          (o_write_enable),
    .o_select_in_vblank      (o_sel_in),
    .o_select_clr_vblank_irq (o_sel_clr),
    .i_vblank_irq            (i_vblank_irq),
    .o_busy                  (o_busy),
    .o_done                  (o_done),
    .o_overrun               (o_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_fail = 0;

  // Expected write: {clr_select, data_oe, address, data}
  logic [19:0] exp_wr[$];
  bit          exp_ov[$];
  int          exp_dcyc[$];
  logic [7:0]  src_mem[0:65535];

  int launch_cyc = 0;
  int wait_cyc = 0;
  int drop_after = 1000;
  int wr_cnt = 0;
  int lat_max = 0;
  int lat_left = 0;

  // Environment: vblank status window and source-memory responder
  always @(negedge clk) begin
    if (o_write_enable && !o_sel_clr) wr_cnt++;
    i_data_in = {7'($urandom), ((cyc - launch_cyc) >= wait_cyc) && (wr_cnt < drop_after)};
    if (o_src_req) begin
      if (lat_left == 0) begin
        i_src_ack  = 1'b1;
        i_src_data = src_mem[o_src_addr];
        lat_left   = $urandom_range(0, lat_max);
      end else begin
        lat_left--;
        i_src_ack = 1'b0;
      end
    end else begin
      i_src_ack = 1'b0;
    end
  end

  logic [19:0] m_exp, m_got;
  bit          m_ov;
  int          m_dc;

  always @(negedge clk) begin
    if (rst_n) begin
      n_chk++;
      if ((o_sel_in && o_sel_clr) || (o_data_oe && o_sel_in) || (o_write_enable && o_sel_in) ||
          (o_src_req && (o_sel_in || o_sel_clr))) begin
        n_fail++;
        $display("FAIL bus_excl cyc=%0d sel_in=%b sel_clr=%b oe=%b we=%b req=%b", cyc, o_sel_in,
                 o_sel_clr, o_data_oe, o_write_enable, o_src_req);
      end
      if (o_write_enable) begin
        n_chk++;
        m_got = {o_sel_clr, o_data_oe, o_address, o_data_out};
        if (exp_wr.size() == 0) begin
          n_fail++;
          $display("FAIL write_unexpected cyc=%0d got=%h required none", cyc, m_got);
        end else begin
          m_exp = exp_wr.pop_front();
          if (m_got !== m_exp) begin
            n_fail++;
            $display("FAIL write cyc=%0d got=%h required=%h", cyc, m_got, m_exp);
          end
        end
      end
      if (o_src_req) begin
        n_chk++;
        if ((cyc - launch_cyc) <= wait_cyc) begin
          n_fail++;
          $display("FAIL src_req_early cyc=%0d got since_launch=%0d required >%0d", cyc,
                   cyc - launch_cyc, wait_cyc);
        end
      end
      if (o_done) begin
        n_chk++;
        if (exp_ov.size() == 0) begin
          n_fail++;
          $display("FAIL done_unexpected cyc=%0d got done=1 required 0", cyc);
        end else begin
          m_ov = exp_ov.pop_front();
          m_dc = exp_dcyc.pop_front();
          if (o_overrun !== m_ov || (m_dc >= 0 && cyc != m_dc)) begin
            n_fail++;
            $display("FAIL done cyc=%0d got overrun=%b required overrun=%b at cyc %0d", cyc,
                     o_overrun, m_ov, m_dc);
          end
        end
      end
    end
  end

  // Transfer-level reference: CLR write, then bytes until length or blanking ends
  task automatic push_model(input logic [SW-1:0] s, input logic [AW-1:0] d, input int len,
                            input int drop, input int dcyc);
    int n;
    logic [AW-1:0] a;
    logic [SW-1:0] sa;
    if (len == 0) begin
      exp_ov.push_back(1'b0);
      exp_dcyc.push_back(dcyc);
      return;
    end
    exp_wr.push_back({1'b1, 1'b1, AW'(0), 8'h00});
    n = (drop < len) ? drop : len;
    for (int i = 0; i < n; i++) begin
      a  = d + AW'(i);
      sa = s + SW'(i);
      exp_wr.push_back({1'b0, 1'b1, a, src_mem[sa]});
    end
    exp_ov.push_back(drop < len);
    exp_dcyc.push_back(-1);
  endtask

  task automatic issue(input logic [SW-1:0] s, input logic [AW-1:0] d, input int len,
                       input int w, input int drop);
    @(negedge clk);
    wr_cnt     = 0;
    wait_cyc   = w;
    drop_after = drop;
    launch_cyc = cyc;
    push_model(s, d, len, drop, (len == 0) ? cyc + 1 : -1);
    i_src_base = s;
    i_dst_base = d;
    i_length   = LW'(len);
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!o_done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (t >= 3000) begin
      n_fail++;
      $display("FAIL done_timeout got no done in %0d cycles required done", t);
    end
    repeat (2) @(negedge clk);
    n_chk++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_done got busy=%b required 0", o_busy);
    end
  endtask

  task automatic run_xfer(input logic [SW-1:0] s, input logic [AW-1:0] d, input int len,
                          input int w, input int drop);
    issue(s, d, len, w, drop);
    wait_done();
  endtask

  initial begin
    int len, t;
    for (int i = 0; i < 65536; i++) src_mem[i] = 8'($urandom);

    repeat (3) @(negedge clk);
    n_chk++;
    if ({o_busy, o_done, o_overrun, o_write_enable, o_data_oe, o_src_req, o_sel_in, o_sel_clr,
         o_address, o_src_addr, o_data_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got busy=%b done=%b ov=%b we=%b oe=%b req=%b required all 0",
               o_busy, o_done, o_overrun, o_write_enable, o_data_oe, o_src_req);
    end
    rst_n = 1'b1;

    lat_max = 0;
    run_xfer(16'h1234, 10'h010, 4, 0, 1000);
    lat_max = 2;
    run_xfer(16'h0100, 10'h200, 5, 20, 1000);
    run_xfer(16'h4000, 10'h080, 8, 0, 3);
    run_xfer(16'h5000, 10'h090, 3, 0, 1000);

    // Auto launch on vblank_irq rising edge; start while busy must be ignored
    @(negedge clk);
    i_vblank_irq = 1'b0;
    i_auto_en    = 1'b1;
    i_src_base   = 16'h6000;
    i_dst_base   = 10'h300;
    i_length     = LW'(6);
    @(negedge clk);
    wr_cnt = 0; wait_cyc = 0; drop_after = 1000; launch_cyc = cyc;
    push_model(16'h6000, 10'h300, 6, 1000, -1);
    i_vblank_irq = 1'b1;
    @(negedge clk);
    i_auto_en = 1'b0;
    repeat (2) @(negedge clk);
    i_src_base = 16'h7000;
    i_dst_base = 10'h123;
    i_length   = LW'(9);
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done();
    i_vblank_irq = 1'b0;

    run_xfer(16'hFFFE, 10'(2 ** AW - 2), 4, 1, 1000);
    run_xfer(16'h0000, 10'h155, 0, 0, 1000);

    for (int k = 0; k < 10; k++) begin
      len = (k == 4) ? 0 : int'($urandom_range(1, 12));
      lat_max = $urandom_range(0, 2);
      run_xfer(16'($urandom), 10'($urandom), len, $urandom_range(0, 4),
               ($urandom_range(0, 1) == 1 || len == 0) ? 1000 : int'($urandom_range(1, len)));
    end

    // Reset in the middle of a data write
    issue(16'h2222, 10'h040, 6, 0, 1000);
    t = 0;
    while (!(o_write_enable && !o_sel_clr) && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (t >= 200) begin
      n_fail++;
      $display("FAIL reset_wait got no data write required one");
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({o_write_enable, o_data_oe, o_busy, o_done} !== 4'b0) begin
      n_fail++;
      $display("FAIL async_reset got we=%b oe=%b busy=%b done=%b required 0000", o_write_enable,
               o_data_oe, o_busy, o_done);
    end
    exp_wr.delete();
    exp_ov.delete();
    exp_dcyc.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (o_busy !== 1'b0 || o_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset got busy=%b ov=%b required 0 0", o_busy, o_overrun);
    end
    lat_max = 1;
    run_xfer(16'h3333, 10'h3F0, 7, 2, 1000);

    repeat (3) @(negedge clk);
    n_chk++;
    if (exp_wr.size() != 0 || exp_ov.size() != 0) begin
      n_fail++;
      $display("FAIL leftover got %0d writes %0d dones pending required 0", exp_wr.size(),
               exp_ov.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vram_dma.md
Name: vram_dma

Overview:
- CPU-side initiator for the GPU's VRAM/vblank interface: copies a block of bytes from a system-memory source port into VRAM during vertical blank.
- Clears the vblank IRQ, polls the in-vblank status, then streams bytes with one write strobe per byte.
- Aborts with an overrun flag if blanking ends before the block completes.

Parameters:
- ADDR_W, default `VRAM_ADDR_WIDTH: VRAM address width.
- SRC_W, default 16: source address width.
- LEN_W, default 12: byte-count width.

Ports:
- clk  in  1  GPU pixel clock (12.5875 MHz).
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle launch pulse.
- auto_en  in  1  launch on each rising edge of vblank_irq.
- src_base  in  SRC_W  first source byte address; latched at launch.
- dst_base  in  ADDR_W  first VRAM address; latched at launch.
- length  in  LEN_W  byte count; latched at launch.
- src_addr  out  SRC_W  source read address.
- src_req  out  1  source read request.
- src_ack  in  1  source data valid this cycle.
- src_data  in  8  source byte.
- address  out  ADDR_W  VRAM address.
- data_out  out  8  write data.
- data_oe  out  1  drive the shared data bus.
- data_in  in  8  shared data bus, read side.
- write_enable  out  1  VRAM/register write strobe.
- SELECT_in_vblank  out  1  status read select.
- SELECT_clr_vblank_irq  out  1  IRQ clear select.
- vblank_irq  in  1  GPU vblank interrupt.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- overrun  out  1  sticky; last transfer aborted.

Behaviour:
- Reset (async, rst low): state IDLE; all outputs 0; counters 0; overrun 0. Any in-flight write strobe drops immediately.
- Launch: start, or auto_en with vblank_irq rising (previous sample 0, current 1), while in IDLE only.
  - Launch requests while busy are ignored.
  - Launch latches bases and length and clears overrun.
  - length==0: done pulses the next cycle; no bus activity.
- FSM, one state per cycle unless noted:
  - IDLE -> CLR on launch.
  - CLR: write_enable=1, SELECT_clr_vblank_irq=1, data_oe=1, data_out=0. Next state CHECK.
  - CHECK: SELECT_in_vblank=1, data_oe=0; sample data_in[0] at the clock edge.
    - Bit 1 -> FETCH.
    - Bit 0 with no byte written yet -> stay in CHECK (wait for blanking).
    - Bit 0 after at least one byte written -> ABORT.
  - FETCH: src_req=1, src_addr=src_base+idx; hold until src_ack. On the ack edge, latch src_data and go to WRITE.
  - WRITE: address=dst_base+idx, data_out=latched byte, data_oe=1, write_enable=1 for exactly one cycle; then idx+=1.
    - idx==length -> FIN; else -> CHECK.
  - FIN: done=1 for one cycle -> IDLE.
  - ABORT: overrun=1, done=1 for one cycle -> IDLE.
- busy=1 in every state except IDLE.
- Bus exclusivity:
  - At most one SELECT line high per cycle.
  - data_oe never high in CHECK.
  - write_enable high only in CLR and WRITE.
  - Selects low in FETCH and WRITE.
- Arithmetic: address and src_addr are modulo 2^ADDR_W and 2^SRC_W; wrap silently.
- Throughput: 3 cycles per byte plus source ack latency.
- auto_en edge detector registers vblank_irq every cycle regardless of state.

Test Plan:
- Reset mid-WRITE (rst low with write_enable=1) -> write_enable, data_oe, busy, done all 0 the same cycle; IDLE after release.
- start, length=4, dst_base=0x010, src_ack the cycle after each src_req, status bit always 1 -> one CLR write, then writes to 0x010..0x013 with source bytes in order; done pulses once; overrun=0.
- start with status bit 0 for 20 cycles, then 1 -> no src_req and no VRAM writes during the wait; transfer then completes normally.
- length=8 with status dropping to 0 after the 3rd write -> exactly 3 writes, overrun=1, done pulses once.
- auto_en=1, vblank_irq 0->1 -> launch; start pulse while busy -> no second transfer.
- dst_base=2^ADDR_W-2, length=4 -> address sequence max-1, max, 0, 1; length=0 -> done the next cycle, no strobes.
